ex_stage: RTL and testbench
===========================

Name: ex_stage

Overview:
- Execute stage; consumes the registered ID bundle (id_en, id_pc, id_insn, id_gpr_we_, id_dst_addr, id_alu_op, id_alu_in_0/1, id_mem_op, id_gpr_data).
- Computes the ALU result, including an iterative 32-cycle unsigned multiplier.
- Registers the EX/MEM bundle for the memory stage.
- Drives ex_stall back to the ID register so it holds its contents while a multiply is in progress.

Parameters:
- ALU_OP_W, 4, width of alu op code (matches `DATA_WIDTH_ALU_OP)
- MEM_OP_W, 3, width of mem op code (matches `DATA_WIDTH_MEM_OP)
- GPR_ADDR_W, 5, destination register address width
- XLEN, 32, data path width (fixed 32; other values unsupported)

Ports:
- clk  in  1  clock; all state on posedge
- reset  in  1  synchronous, active-low reset
- flush  in  1  kill the in-flight EX instruction (branch/trap)
- id_en  in  1  ID bundle valid
- id_pc  in  30  word PC
- id_gpr_we_  in  1  GPR write enable, active-low
- id_dst_addr  in  GPR_ADDR_W  destination register
- id_alu_op  in  ALU_OP_W  operation code
- id_alu_in_0  in  XLEN  operand A
- id_alu_in_1  in  XLEN  operand B
- id_mem_op  in  MEM_OP_W  memory op, passed through
- id_gpr_data  in  XLEN  store data, passed through
- ex_stall  out  1  hold ID register; combinational
- ex_en  out  1  EX bundle valid
- ex_pc  out  30  registered id_pc
- ex_gpr_we_  out  1  registered write enable, active-low
- ex_dst_addr  out  GPR_ADDR_W  registered destination
- ex_alu_out  out  XLEN  ALU/multiplier result
- ex_mem_op  out  MEM_OP_W  registered mem op
- ex_gpr_data  out  XLEN  registered store data

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-low; it is sampled only on posedge clk.
- Reset values: all ex_* = 0, except ex_gpr_we_ = 1 (write disabled). State = IDLE, counter = 0. ex_stall is combinational and therefore 0 while in IDLE.
- Op codes:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR
  - 5 SLL, 6 SRL, 7 SRA; shift amount = in_1[4:0]
  - 8 SLT (signed), 9 SLTU (result 1 or 0)
  - 10 MUL (low 32 bits of the unsigned product), 11 MULHU (high 32 bits)
  - 12..15 → result 0
  - ADD/SUB wrap modulo 2^32.
- Single-cycle ops (state IDLE): on each posedge, ex_pc/dst_addr/mem_op/gpr_data/alu_out take the current inputs.
  - ex_en = id_en.
  - ex_gpr_we_ = id_gpr_we_ if id_en = 1, else 1.
  - Latency 1 cycle.
- FSM states: IDLE, BUSY.
  - IDLE → BUSY when id_en = 1, op ∈ {10, 11} and flush = 0.
    - Operands are latched; counter = 0; 64-bit accumulator = 0.
    - ex_en <= 0 and ex_gpr_we_ <= 1 (bubble).
  - BUSY: each cycle, if multiplier bit[counter] = 1, add multiplicand << counter into the accumulator; counter++.
  - BUSY → IDLE at the edge when counter = 31.
    - The full ID bundle is registered, with ex_alu_out = final low or high word.
    - ex_en <= 1; ex_gpr_we_ <= id_gpr_we_.
  - In BUSY with counter < 31, ex_en <= 0 and ex_gpr_we_ <= 1 (bubble).
- ex_stall = (IDLE & id_en & mul-op & !flush) | (BUSY & counter != 31 & !flush).
  - The ID register therefore advances on the same edge the result is written.
  - Multiply latency: 33 cycles from presentation to a valid ex_en.
- ID inputs are required to stay stable while ex_stall = 1; the stage re-reads pass-through fields at completion.
- Flush: highest priority after reset, in any state.
  - Next edge: ex_en <= 0, ex_gpr_we_ <= 1, state <= IDLE, counter <= 0.
  - A multiply in progress is abandoned.
  - ex_stall = 0 while flush = 1.
- Reset mid-multiply: returns everything to reset values; no result is produced.
- Back-to-back multiplies: the second is detected in IDLE on the cycle after completion. There is no gap other than the IDLE detect cycle.

Optional Feature:
- Macro: SIICPU_EX_MUL_EN.
- Defined: iterative multiplier, BUSY state and ex_stall behave as specified above.
- Undefined:
  - No FSM or counter.
  - Ops 10 and 11 complete single-cycle with ex_alu_out = 0.
  - ex_stall tied to 0.

Test Plan:
- Reset low for 2 edges mid-traffic → all ex_* = 0, ex_gpr_we_ = 1, ex_stall = 0.
- ADD 0xFFFFFFFF + 1, id_en = 1, dst = 5, id_gpr_we_ = 0 → next edge: ex_alu_out = 0, ex_en = 1, ex_dst_addr = 5, ex_gpr_we_ = 0.
- SRA 0x80000000 by in_1 = 0x24 (amount 4) → 0xF8000000. SLT −1 vs 1 → 1. SLTU −1 vs 1 → 0.
- MUL 0x12345678 × 0x9ABCDEF0 with macro defined →
  - ex_stall = 1 for 32 cycles, then 0.
  - ex_en = 0 until cycle 33, then ex_en = 1 with ex_alu_out = 0x242D2080.
  - Repeating with MULHU → 0x0B00EA4E.
- Flush asserted at BUSY counter = 10 → next edge: ex_en = 0, ex_stall = 0, state IDLE. A following ADD 2 + 3 yields 5 after 1 cycle.
- id_en = 0 with id_gpr_we_ = 0 → ex_en = 0, ex_gpr_we_ = 1. With the macro undefined, MUL 3 × 4 → ex_alu_out = 0 after 1 cycle and ex_stall stays 0.

Source files
------------

// File: rtl/ex_stage.sv
// ex_stage: execute stage; ALU, optional iterative 32-cycle unsigned
// multiplier (macro SIICPU_EX_MUL_EN), and the EX/MEM bundle register.
//
// Ports:
//   clk, reset (sync, active-low), flush
//   id_*  : registered ID bundle (valid, pc, we_, dst, alu op/operands,
//           mem op, store data)
//   ex_stall : combinational hold request to the ID register
//   ex_*  : registered EX/MEM bundle
//
// With SIICPU_EX_MUL_EN undefined, MUL/MULHU complete in one cycle
// with a zero result and ex_stall is tied low.
module ex_stage #(
    parameter int ALU_OP_W   = 4,
    parameter int MEM_OP_W   = 3,
    parameter int GPR_ADDR_W = 5,
    parameter int XLEN       = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  id_en,
    input  logic [29:0]           id_pc,
    input  logic                  id_gpr_we_,
    input  logic [GPR_ADDR_W-1:0] id_dst_addr,
    input  logic [ALU_OP_W-1:0]   id_alu_op,
    input  logic [XLEN-1:0]       id_alu_in_0,
    input  logic [XLEN-1:0]       id_alu_in_1,
    input  logic [MEM_OP_W-1:0]   id_mem_op,
    input  logic [XLEN-1:0]       id_gpr_data,
    output logic                  ex_stall,
    output logic                  ex_en,
    output logic [29:0]           ex_pc,
    output logic                  ex_gpr_we_,
    output logic [GPR_ADDR_W-1:0] ex_dst_addr,
    output logic [XLEN-1:0]       ex_alu_out,
    output logic [MEM_OP_W-1:0]   ex_mem_op,
    output logic [XLEN-1:0]       ex_gpr_data
);

    localparam logic [ALU_OP_W-1:0] OP_ADD   = ALU_OP_W'(0);
    localparam logic [ALU_OP_W-1:0] OP_SUB   = ALU_OP_W'(1);
    localparam logic [ALU_OP_W-1:0] OP_AND   = ALU_OP_W'(2);
    localparam logic [ALU_OP_W-1:0] OP_OR    = ALU_OP_W'(3);
    localparam logic [ALU_OP_W-1:0] OP_XOR   = ALU_OP_W'(4);
    localparam logic [ALU_OP_W-1:0] OP_SLL   = ALU_OP_W'(5);
    localparam logic [ALU_OP_W-1:0] OP_SRL   = ALU_OP_W'(6);
    localparam logic [ALU_OP_W-1:0] OP_SRA   = ALU_OP_W'(7);
    localparam logic [ALU_OP_W-1:0] OP_SLT   = ALU_OP_W'(8);
    localparam logic [ALU_OP_W-1:0] OP_SLTU  = ALU_OP_W'(9);
`ifdef SIICPU_EX_MUL_EN
    localparam logic [ALU_OP_W-1:0] OP_MUL   = ALU_OP_W'(10);
    localparam logic [ALU_OP_W-1:0] OP_MULHU = ALU_OP_W'(11);
    localparam int CW = $clog2(XLEN);
`endif

    logic [4:0]      shamt;
    logic [XLEN-1:0] alu_res;

    assign shamt = id_alu_in_1[4:0];

    // MUL/MULHU fall into the default arm: zero unless the
    // multiplier path below supplies the result.
    always_comb begin
        alu_res = '0;
        unique case (id_alu_op)
            OP_ADD:  alu_res = id_alu_in_0 + id_alu_in_1;
            OP_SUB:  alu_res = id_alu_in_0 - id_alu_in_1;
            OP_AND:  alu_res = id_alu_in_0 & id_alu_in_1;
            OP_OR:   alu_res = id_alu_in_0 | id_alu_in_1;
            OP_XOR:  alu_res = id_alu_in_0 ^ id_alu_in_1;
            OP_SLL:  alu_res = id_alu_in_0 << shamt;
            OP_SRL:  alu_res = id_alu_in_0 >> shamt;
            OP_SRA:  alu_res = $signed(id_alu_in_0) >>> shamt;
            OP_SLT:  alu_res = XLEN'($signed(id_alu_in_0) <
                                     $signed(id_alu_in_1));
            OP_SLTU: alu_res = XLEN'(id_alu_in_0 < id_alu_in_1);
            default: alu_res = '0;
        endcase
    end

`ifdef SIICPU_EX_MUL_EN
    typedef enum logic {IDLE, BUSY} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [XLEN-1:0]   mcand_q, mcand_d;
    logic [XLEN-1:0]   mplier_q, mplier_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [2*XLEN-1:0] pp;
    logic [2*XLEN-1:0] acc_sum;
    logic [XLEN-1:0]   mul_res;
    logic              is_mul;
    logic              last;

    assign is_mul = (id_alu_op == OP_MUL) || (id_alu_op == OP_MULHU);
    assign last   = (cnt_q == CW'(XLEN-1));
    assign pp     = mplier_q[cnt_q] ?
                    ({{XLEN{1'b0}}, mcand_q} << cnt_q) : '0;
    // Final bit is folded in combinationally so the result is
    // written on the same edge the counter reaches 31.
    assign acc_sum = acc_q + pp;
    assign mul_res = (id_alu_op == OP_MULHU) ?
                     acc_sum[2*XLEN-1:XLEN] : acc_sum[XLEN-1:0];

    assign ex_stall = !flush &&
                      (((state_q == IDLE) && id_en && is_mul) ||
                       ((state_q == BUSY) && !last));
`else
    assign ex_stall = 1'b0;
`endif

    logic                  en_d;
    logic                  we_d;
    logic [29:0]           pc_d;
    logic [GPR_ADDR_W-1:0] dst_d;
    logic [XLEN-1:0]       out_d;
    logic [MEM_OP_W-1:0]   mem_d;
    logic [XLEN-1:0]       gpr_d;

    always_comb begin
        en_d  = ex_en;
        we_d  = ex_gpr_we_;
        pc_d  = ex_pc;
        dst_d = ex_dst_addr;
        out_d = ex_alu_out;
        mem_d = ex_mem_op;
        gpr_d = ex_gpr_data;
`ifdef SIICPU_EX_MUL_EN
        state_d  = state_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
`endif
        if (flush) begin
            en_d = 1'b0;
            we_d = 1'b1;
`ifdef SIICPU_EX_MUL_EN
            state_d = IDLE;
            cnt_d   = '0;
`endif
        end
`ifdef SIICPU_EX_MUL_EN
        else if (state_q == BUSY) begin
            acc_d = acc_sum;
            cnt_d = cnt_q + CW'(1);
            if (last) begin
                state_d = IDLE;
                cnt_d   = '0;
                en_d    = 1'b1;
                we_d    = id_gpr_we_;
                pc_d    = id_pc;
                dst_d   = id_dst_addr;
                out_d   = mul_res;
                mem_d   = id_mem_op;
                gpr_d   = id_gpr_data;
            end else begin
                en_d = 1'b0;
                we_d = 1'b1;
            end
        end else if (id_en && is_mul) begin
            state_d  = BUSY;
            cnt_d    = '0;
            acc_d    = '0;
            mcand_d  = id_alu_in_0;
            mplier_d = id_alu_in_1;
            en_d     = 1'b0;
            we_d     = 1'b1;
        end
`endif
        else begin
            en_d  = id_en;
            we_d  = id_en ? id_gpr_we_ : 1'b1;
            pc_d  = id_pc;
            dst_d = id_dst_addr;
            out_d = alu_res;
            mem_d = id_mem_op;
            gpr_d = id_gpr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ex_en       <= 1'b0;
            ex_gpr_we_  <= 1'b1;
            ex_pc       <= '0;
            ex_dst_addr <= '0;
            ex_alu_out  <= '0;
            ex_mem_op   <= '0;
            ex_gpr_data <= '0;
`ifdef SIICPU_EX_MUL_EN
            state_q  <= IDLE;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
`endif
        end else begin
            ex_en       <= en_d;
            ex_gpr_we_  <= we_d;
            ex_pc       <= pc_d;
            ex_dst_addr <= dst_d;
            ex_alu_out  <= out_d;
            ex_mem_op   <= mem_d;
            ex_gpr_data <= gpr_d;
`ifdef SIICPU_EX_MUL_EN
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
`endif
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: scoreboard bench for ex_stage.
// Driver pushes expected EX bundles; monitor pops on every ex_en.
module tb_ex_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        id_en;
    logic [29:0] id_pc;
    logic        id_gpr_we_;
    logic [4:0]  id_dst_addr;
    logic [3:0]  id_alu_op;
    logic [31:0] id_alu_in_0;
    logic [31:0] id_alu_in_1;
    logic [2:0]  id_mem_op;
    logic [31:0] id_gpr_data;
    logic        ex_stall;
    logic        ex_en;
    logic [29:0] ex_pc;
    logic        ex_gpr_we_;
    logic [4:0]  ex_dst_addr;
    logic [31:0] ex_alu_out;
    logic [2:0]  ex_mem_op;
    logic [31:0] ex_gpr_data;

    always #5 clk = ~clk;

    ex_stage dut (
        .clk(clk), .reset(reset), .flush(flush),
        .id_en(id_en), .id_pc(id_pc), .id_gpr_we_(id_gpr_we_),
        .id_dst_addr(id_dst_addr), .id_alu_op(id_alu_op),
        .id_alu_in_0(id_alu_in_0), .id_alu_in_1(id_alu_in_1),
        .id_mem_op(id_mem_op), .id_gpr_data(id_gpr_data),
        .ex_stall(ex_stall), .ex_en(ex_en), .ex_pc(ex_pc),
        .ex_gpr_we_(ex_gpr_we_), .ex_dst_addr(ex_dst_addr),
        .ex_alu_out(ex_alu_out), .ex_mem_op(ex_mem_op),
        .ex_gpr_data(ex_gpr_data)
    );

    typedef struct {
        string       nm;
        logic [31:0] out;
        logic [4:0]  dst;
        logic        we;
        logic [29:0] pc;
        logic [31:0] gpr;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   pc_ctr = 100;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset && ex_en) begin
            if (sb.size() == 0) begin
                chk("unexpected_ex_en", 32'(ex_en), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk({e.nm, ".out"}, ex_alu_out, e.out);
                chk({e.nm, ".dst"}, 32'(ex_dst_addr), 32'(e.dst));
                chk({e.nm, ".we_"}, 32'(ex_gpr_we_), 32'(e.we));
                chk({e.nm, ".pc"}, 32'(ex_pc), 32'(e.pc));
                chk({e.nm, ".gpr"}, ex_gpr_data, e.gpr);
            end
        end
    end

    task automatic set_in(input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] dst,
                          input logic we);
        pc_ctr++;
        id_en       = 1'b1;
        id_pc       = 30'(pc_ctr);
        id_alu_op   = op;
        id_alu_in_0 = a;
        id_alu_in_1 = b;
        id_dst_addr = dst;
        id_gpr_we_  = we;
        id_mem_op   = 3'(pc_ctr);
        id_gpr_data = ~a;
    endtask

    task automatic push(input string nm, input logic [31:0] out);
        exp_t e;
        e.nm  = nm;
        e.out = out;
        e.dst = id_dst_addr;
        e.we  = id_gpr_we_;
        e.pc  = id_pc;
        e.gpr = id_gpr_data;
        sb.push_back(e);
    endtask

    task automatic single(input string nm, input logic [3:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] dst, input logic [31:0] exp);
        set_in(op, a, b, dst, 1'b0);
        push(nm, exp);
        @(posedge clk); #1;
    endtask

    task automatic check_reset_vals();
        chk("rst.en", 32'(ex_en), 32'd0);
        chk("rst.we_", 32'(ex_gpr_we_), 32'd1);
        chk("rst.pc", 32'(ex_pc), 32'd0);
        chk("rst.dst", 32'(ex_dst_addr), 32'd0);
        chk("rst.out", ex_alu_out, 32'd0);
        chk("rst.mem", 32'(ex_mem_op), 32'd0);
        chk("rst.gpr", ex_gpr_data, 32'd0);
        chk("rst.stall", 32'(ex_stall), 32'd0);
    endtask

`ifdef SIICPU_EX_MUL_EN
    task automatic mul_test(input string nm, input logic [3:0] op,
                            input logic [31:0] exp);
        int   n;
        logic early;
        n = 0;
        early = 1'b0;
        set_in(op, 32'h12345678, 32'h9ABCDEF0, 5'd9, 1'b0);
        push(nm, exp);
        while (ex_stall && n < 40) begin
            @(posedge clk); #1;
            n++;
            if (ex_en) early = 1'b1;
        end
        chk({nm, ".stall_cycles"}, 32'(n), 32'd32);
        chk({nm, ".early_en"}, 32'(early), 32'd0);
        @(posedge clk); #1;
        id_en = 1'b0;
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b0;
        flush = 1'b0;
        id_en = 1'b0;
        set_in(4'd0, 0, 0, 0, 1'b1);
        id_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_vals();
        reset = 1'b1;

        single("add_wrap", 4'd0, 32'hFFFFFFFF, 32'd1, 5'd5, 32'h0);
        single("sub", 4'd1, 32'd5, 32'd7, 5'd6, 32'hFFFFFFFE);
        single("and", 4'd2, 32'hF0F0, 32'hFF00, 5'd7, 32'hF000);
        single("or", 4'd3, 32'hF0F0, 32'hFF00, 5'd8, 32'hFFF0);
        single("xor", 4'd4, 32'hF0F0, 32'hFF00, 5'd1, 32'h0FF0);
        single("sll", 4'd5, 32'd1, 32'd31, 5'd2, 32'h80000000);
        single("srl", 4'd6, 32'h80000000, 32'h24, 5'd3, 32'h08000000);
        single("sra", 4'd7, 32'h80000000, 32'h24, 5'd4, 32'hF8000000);
        single("slt", 4'd8, 32'hFFFFFFFF, 32'd1, 5'd10, 32'd1);
        single("sltu", 4'd9, 32'hFFFFFFFF, 32'd1, 5'd11, 32'd0);
        single("op12", 4'd12, 32'h5, 32'h6, 5'd12, 32'd0);

        set_in(4'd0, 32'd1, 32'd1, 5'd13, 1'b0);
        id_en = 1'b0;
        @(posedge clk); #1;
        chk("noen.en", 32'(ex_en), 32'd0);
        chk("noen.we_", 32'(ex_gpr_we_), 32'd1);

`ifdef SIICPU_EX_MUL_EN
        mul_test("mul", 4'd10, 32'h242D2080);
        mul_test("mulhu", 4'd11, 32'h0B00EA4E);

        set_in(4'd10, 32'd3, 32'd4, 5'd14, 1'b0);
        repeat (11) @(posedge clk);
        #1;
        chk("flush.pre_stall", 32'(ex_stall), 32'd1);
        flush = 1'b1;
        #1;
        chk("flush.stall", 32'(ex_stall), 32'd0);
        @(posedge clk); #1;
        flush = 1'b0;
        id_en = 1'b0;
        chk("flush.en", 32'(ex_en), 32'd0);
        chk("flush.after_stall", 32'(ex_stall), 32'd0);
`else
        set_in(4'd10, 32'd3, 32'd4, 5'd14, 1'b0);
        #1;
        chk("mul_off.stall", 32'(ex_stall), 32'd0);
        push("mul_off", 32'd0);
        @(posedge clk); #1;
        id_en = 1'b0;
`endif
        single("add_after", 4'd0, 32'd2, 32'd3, 5'd15, 32'd5);
        id_en = 1'b0;
        @(posedge clk); #1;

`ifdef SIICPU_EX_MUL_EN
        set_in(4'd11, 32'h12345678, 32'h9ABCDEF0, 5'd16, 1'b0);
        repeat (5) @(posedge clk);
        #1;
`endif
        reset = 1'b0;
        set_in(4'd0, 32'd7, 32'd8, 5'd17, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check_reset_vals();
        id_en = 1'b0;
        reset = 1'b1;

        repeat (40) @(posedge clk);
        #1;
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
